// File: rtl/tx_feeder_pkg.sv
// Shared constants for the UART transmit feeder: FSM state encoding,
// default FIFO geometry and the WAIT_BUSY timeout.
package tx_feeder_pkg;

    localparam int unsigned DEF_DEPTH        = 16;
    localparam int unsigned DEF_AW           = 4;
    localparam int unsigned WAIT_BUSY_CYCLES = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/tx_feeder_fifo.sv
// Byte-wide synchronous FIFO with show-ahead read data and registered
// level/full flags; writes while full and reads while empty are ignored.
module sync_fifo_8b
    import tx_feeder_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned AW    = DEF_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          r_full;
    logic          w_empty;
    logic          w_wr_acc;
    logic          w_rd_acc;
    logic [AW:0]   w_level_nxt;

    assign w_empty  = (r_level == '0);
    assign w_wr_acc = wr_en & ~r_full;
    assign w_rd_acc = rd_en & ~w_empty;

    always_comb begin
        w_level_nxt = r_level;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_level_nxt = r_level + (AW+1)'(1);
            2'b01:   w_level_nxt = r_level - (AW+1)'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    // Storage is deliberately left out of reset; pointers alone define contents.
    always_ff @(posedge clk) begin
        if (w_wr_acc)
            r_mem[r_wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_wr_acc)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd_acc)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == (AW+1)'(DEPTH));
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign full    = r_full;
    assign empty   = w_empty;
    assign level   = r_level;

endmodule

// File: rtl/tx_feeder.sv
// Buffers user bytes and hands them one at a time to a UART transmitter,
// waiting for its ready handshake to drop and rise again between bytes.
module tx_feeder
    import tx_feeder_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned AW    = DEF_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic [AW:0]   level,
    output logic          overflow,
    input  logic          tx_rdy,
    output logic          tx_din_vld,
    output logic [7:0]    tx_din,
    output logic          busy
);

    tx_state_e   r_state;
    tx_state_e   w_state_nxt;
    logic [1:0]  r_wb_cnt;
    logic [7:0]  r_tx_din;
    logic        r_overflow;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic [7:0]  w_rd_data;

    sync_fifo_8b #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (w_pop),
        .rd_data (w_rd_data),
        .full    (w_full),
        .empty   (w_empty),
        .level   (level)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && tx_rdy) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND:
                w_state_nxt = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                // A transmitter that never drops ready must not stall the feeder.
                if (!tx_rdy)
                    w_state_nxt = ST_WAIT_DONE;
                else if (r_wb_cnt == 2'(WAIT_BUSY_CYCLES - 1))
                    w_state_nxt = ST_IDLE;
            end
            ST_WAIT_DONE: begin
                if (tx_rdy)
                    w_state_nxt = ST_IDLE;
            end
            default:
                w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_wb_cnt   <= '0;
            r_tx_din   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wb_cnt   <= (r_state == ST_WAIT_BUSY) ? r_wb_cnt + 2'd1 : 2'd0;
            r_overflow <= wr_en & w_full;
            if (w_pop)
                r_tx_din <= w_rd_data;
        end
    end

    assign full       = w_full;
    assign overflow   = r_overflow;
    assign tx_din     = r_tx_din;
    assign tx_din_vld = (r_state == ST_SEND);
    assign busy       = !w_empty || (r_state != ST_IDLE);

endmodule

// File: tb/tb_tx_feeder.sv
// Directed bench for tx_feeder with a behavioural transmitter whose ready
// drops for a short frame after each byte, or is forced to a fixed level.
`timescale 1ns/1ps
module tb_tx_feeder;

    localparam int unsigned FRAME = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = '0;
    logic        full;
    logic [4:0]  level;
    logic        overflow;
    logic        tx_rdy;
    logic        tx_din_vld;
    logic [7:0]  tx_din;
    logic        busy;

    logic        tx_mode = 1'b1;
    logic        force_rdy = 1'b1;
    int unsigned frame_cnt = 0;
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  q_data [$];
    int unsigned q_cyc [$];

    tx_feeder #(
        .DEPTH (16),
        .AW    (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .level      (level),
        .overflow   (overflow),
        .tx_rdy     (tx_rdy),
        .tx_din_vld (tx_din_vld),
        .tx_din     (tx_din),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Transmitter model: busy while din_vld is high and for FRAME cycles after.
    assign tx_rdy = tx_mode ? !(tx_din_vld || frame_cnt != 0) : force_rdy;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_din_vld)
            frame_cnt <= FRAME;
        else if (frame_cnt != 0)
            frame_cnt <= frame_cnt - 1;
    end

    always @(negedge clk) begin
        if (rst_n && tx_din_vld) begin
            q_data.push_back(tx_din);
            q_cyc.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
        if (busy)
            check_eq("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic check_train(input string tag, input int n, input logic [7:0] first, input int unsigned gap);
        check_eq({tag, "_count"}, 32'(q_data.size()), 32'(n));
        for (int i = 0; i < q_data.size() && i < n; i++) begin
            check_eq({tag, "_data"}, 32'(q_data[i]), 32'(first) + 32'(i));
            if (i > 0)
                check_eq({tag, "_gap"}, q_cyc[i] - q_cyc[i-1], gap);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) tick();
        check_eq("rst_level", 32'(level), 32'd0);
        check_eq("rst_full", 32'(full), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        check_eq("rst_vld", 32'(tx_din_vld), 32'd0);
        check_eq("rst_din", 32'(tx_din), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single byte: pulse one edge after the write edge
        wr_data = 8'h55;
        wr_en   = 1'b1;
        tick();
        wr_en = 1'b0;
        check_eq("one_level", 32'(level), 32'd1);
        check_eq("one_vld_early", 32'(tx_din_vld), 32'd0);
        check_eq("one_busy", 32'(busy), 32'd1);
        tick();
        check_eq("one_vld", 32'(tx_din_vld), 32'd1);
        check_eq("one_din", 32'(tx_din), 32'h55);
        check_eq("one_level_pop", 32'(level), 32'd0);
        repeat (11) tick();
        check_eq("one_busy_frame", 32'(busy), 32'd1);
        tick();
        check_eq("one_busy_done", 32'(busy), 32'd0);
        check_eq("one_din_hold", 32'(tx_din), 32'h55);

        // Burst of five: second write coincides with the first pop
        q_data.delete();
        q_cyc.delete();
        for (int i = 1; i <= 5; i++) begin
            wr_data = 8'(i);
            wr_en   = 1'b1;
            tick();
        end
        wr_en = 1'b0;
        check_eq("burst_level", 32'(level), 32'd4);
        wait_idle(300);
        check_train("burst", 5, 8'h01, FRAME + 3);

        // Fill with transmitter held not-ready, then overflow
        tx_mode   = 1'b0;
        force_rdy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_data = 8'hA0 + 8'(i);
            wr_en   = 1'b1;
            tick();
            if (i == 14)
                check_eq("fill15_full", 32'(full), 32'd0);
        end
        check_eq("fill_full", 32'(full), 32'd1);
        check_eq("fill_level", 32'(level), 32'd16);
        check_eq("fill_ovf", 32'(overflow), 32'd0);
        wr_data = 8'hB0;
        tick();
        check_eq("ovf17_pulse", 32'(overflow), 32'd1);
        check_eq("ovf17_level", 32'(level), 32'd16);

        // Write and pop on the same edge while full
        q_data.delete();
        q_cyc.delete();
        wr_data   = 8'hB1;
        force_rdy = 1'b1;
        tick();
        wr_en = 1'b0;
        check_eq("wp_level", 32'(level), 32'd15);
        check_eq("wp_ovf", 32'(overflow), 32'd1);
        check_eq("wp_full", 32'(full), 32'd0);
        check_eq("wp_vld", 32'(tx_din_vld), 32'd1);
        check_eq("wp_din", 32'(tx_din), 32'hA0);
        tick();
        check_eq("wp_ovf_clear", 32'(overflow), 32'd0);

        // Dead transmitter drains the FIFO at one byte per six cycles
        wait_idle(300);
        check_train("drain", 16, 8'hA0, 6);

        // Reset mid-frame with three bytes queued
        tx_mode = 1'b1;
        repeat (12) tick();
        for (int i = 0; i < 4; i++) begin
            wr_data = 8'h11 + 8'(i);
            wr_en   = 1'b1;
            tick();
        end
        wr_en = 1'b0;
        check_eq("mid_level", 32'(level), 32'd3);
        repeat (3) tick();
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_level", 32'(level), 32'd0);
        check_eq("mid_rst_full", 32'(full), 32'd0);
        check_eq("mid_rst_vld", 32'(tx_din_vld), 32'd0);
        check_eq("mid_rst_din", 32'(tx_din), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_ovf", 32'(overflow), 32'd0);
        q_data.delete();
        q_cyc.delete();
        @(negedge clk);
        rst_n   = 1'b1;
        wr_data = 8'h3C;
        wr_en   = 1'b1;
        tick();
        wr_en = 1'b0;
        check_eq("post_rst_level", 32'(level), 32'd1);
        wait_idle(300);
        check_train("post_rst", 1, 8'h3C, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tx_feeder.md
TX_FEEDER -- requirements
Module: tx_feeder

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in bytes (power of two, 2..256).
REQ-002 Parameter AW, default 4, pointer width (log2 DEPTH).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 wr_en  input  1  user write strobe, one byte per cycle.
REQ-006 wr_data  input  8  user byte, sampled when wr_en=1.
REQ-007 full  output  1  FIFO holds DEPTH bytes.
REQ-008 level  output  AW+1  bytes currently stored.
REQ-009 overflow  output  1  one-cycle pulse: wr_en=1 while full=1, byte dropped.
REQ-010 tx_rdy  input  1  downstream UART transmitter ready; low while its din_vld is high or a frame is in flight.
REQ-011 tx_din_vld  output  1  one-cycle byte-valid pulse to transmitter.
REQ-012 tx_din  output  8  byte to transmitter, stable from pulse until next pop.
REQ-013 busy  output  1  high when FIFO non-empty or FSM not in IDLE.

Function
REQ-014 Write: wr_en=1 and full=0 stores wr_data at wr_ptr and increments wr_ptr (mod DEPTH) on the same edge.
REQ-015 Write with full=1 is discarded; pointers and level unchanged; overflow=1 on the next cycle only.
REQ-016 full and level are registered, updated on the edge of the write/pop; level = writes minus pops, never exceeding DEPTH.
REQ-017 Simultaneous accepted write and pop: level unchanged, both pointers advance.
REQ-018 FSM states: IDLE, SEND, WAIT_BUSY, WAIT_DONE; two-bit encoding.
REQ-019 IDLE -> SEND when level!=0 and tx_rdy=1; on that edge pop: tx_din <= mem[rd_ptr], rd_ptr increments mod DEPTH.
REQ-020 SEND: tx_din_vld=1 for exactly this one cycle; unconditional -> WAIT_BUSY.
REQ-021 WAIT_BUSY -> WAIT_DONE when tx_rdy=0; if tx_rdy still 1 after 4 cycles in WAIT_BUSY, -> IDLE (byte treated as accepted, no retry).
REQ-022 WAIT_DONE -> IDLE when tx_rdy=1.
REQ-023 tx_din_vld is 0 in every state except SEND; at most one byte in flight.
REQ-024 Latency: byte written at edge N to empty FIFO with tx_rdy=1 and FSM IDLE gives tx_din_vld=1 during cycle after edge N+1.
REQ-025 Bytes leave in write order; no byte duplicated or lost except per REQ-015.
REQ-026 Back-to-back bytes: next pop occurs on the first IDLE edge with tx_rdy=1, i.e. one cycle after tx_rdy rises.
REQ-027 Pointer wrap: after DEPTH writes and DEPTH pops pointers return to 0 with no data corruption.

Reset
REQ-028 rst_n=0 asynchronously sets: state IDLE, wr_ptr=0, rd_ptr=0, level=0, full=0, overflow=0, tx_din_vld=0, tx_din=0, busy=0.
REQ-029 Reset mid-operation discards all stored bytes; FIFO memory contents need no reset.
REQ-030 First write accepted on the first rising edge after rst_n deasserts.

Structure
REQ-031 Shared package holds FSM state constants and default DEPTH/AW.
REQ-032 FIFO storage and pointers in sub-module sync_fifo_8b (ports: clk, rst_n, wr_en, wr_data, rd_en, rd_data, full, empty, level); FSM in tx_feeder top.
REQ-033 Transmitter ports connect directly: tx_din_vld->din_vld, tx_din->din, rdy->tx_rdy; no glue logic.

Verification (bench with transmitter at bps=2604, 10 bits/frame = 26040 cycles/byte)
REQ-034 Write 0x55 once into empty FIFO -> tx_din_vld pulse 2 cycles later with tx_din=0x55; serial line 0,1,0,1,0,1,0,1,0,1 (LSB first), busy low after frame.
REQ-035 Burst write 0x01..0x05 in 5 consecutive cycles -> level peaks 5 (minus 1 if popped), five pulses in order 0x01..0x05 spaced 26041 cycles.
REQ-036 Write 17 bytes with tx_rdy forced 0 -> full=1 after 16, overflow pulse on 17th write, level=16, 17th byte never transmitted.
REQ-037 Write+pop same cycle at level=16 with tx_rdy=1 -> write rejected, overflow=1; level 15 after pop.
REQ-038 Assert rst_n=0 mid-frame with level=3 -> all outputs reset values same cycle; after release no stale byte sent.
REQ-039 Hold tx_rdy=1 permanently (dead transmitter) -> each byte leaves IDLE->SEND->WAIT_BUSY->IDLE in 6 cycles; FSM never hangs.
